brick_field_ctrl: RTL and testbench
===================================

// Module: brick_field_ctrl
// PURPOSE
//  Owns the live/dead state of the brick wall for the brick breaker game.
//  Loads a fresh wall on start, resolves ball-collision coordinates to a brick, and kills that brick.
//  Tracks bricks remaining and score, and flags level clear.
//  Drives the registered per-pixel brick mask consumed by the VGA colour mux.
// PARAMETERS
//  COLS      5    bricks per row
//  ROWS      4    brick rows
//  BRICK_W   124  brick width, pixels
//  BRICK_H   20   brick height, pixels
//  PITCH_X   128  column pitch, pixels (power of two; col = x >> log2(PITCH_X))
//  PITCH_Y   24   row pitch, pixels (resolved by comparator chain, no divider)
//  TOP_Y     4    y of row 0 top edge; column 0 starts at x=0
//  NB        COLS*ROWS, derived (localparam)
// PORTS
//  clk            in   1      system clock
//  rst            in   1      synchronous, active-low reset
//  start          in   1      1-cycle pulse: load full wall, zero score
//  x              in   10     current VGA pixel x
//  y              in   10     current VGA pixel y
//  active_pixels  in   1      VGA visible region
//  pixel_on       out  1      pixel lies inside a live brick (1-cycle latency)
//  pixel_color    out  24     brick colour for this pixel (0 when !pixel_on)
//  hit_req        in   1      1-cycle pulse: ball contact at (hit_x, hit_y)
//  hit_x          in   10     contact x, sampled with hit_req
//  hit_y          in   10     contact y, sampled with hit_req
//  hit_busy       out  1      hit engine occupied; hit_req ignored while high
//  hit_done       out  1      1-cycle pulse: lookup finished
//  hit_kill       out  1      valid with hit_done: a live brick was destroyed
//  bricks_left    out  $clog2(NB+1)  live brick count
//  score          out  16     bricks destroyed since start, saturates at 16'hFFFF
//  level_clear    out  1      level cleared, held until start/reset
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE, alive bitmap=0, pixel_on=0, pixel_color=0, hit_busy=0,
//   hit_done=0, hit_kill=0, bricks_left=0, score=0, level_clear=0. This also applies mid-FILL or mid-hit.
//  FSM states:
//   IDLE  - wall empty. start -> FILL.
//   FILL  - sets one row of alive bits per cycle, row 0 first. After ROWS cycles: bricks_left=NB -> PLAY.
//           hit_req is ignored. hit_busy=1 throughout FILL.
//   PLAY  - hit engine is active. When bricks_left reaches 0 -> CLEARED.
//   CLEAR(ED) - level_clear=1. start -> FILL.
//  start in any state: clear the bitmap, score=0, level_clear=0, abort any in-flight hit (no hit_done),
//   then enter FILL on the next cycle.
//  Hit engine (PLAY only), 2 stages:
//   Cycle 0: hit_req sampled with !hit_busy. Latch coordinates; hit_busy=1.
//   Cycle 1: compute col and row.
//     Miss conditions: x mod PITCH_X >= BRICK_W; y<TOP_Y; (y-TOP_Y) mod PITCH_Y >= BRICK_H;
//     col>=COLS; row>=ROWS.
//   Cycle 2: hit_done=1. hit_kill=1 iff in-brick and the alive bit was set. On a kill: clear the bit,
//     bricks_left-1, score+1 (saturating). hit_busy drops in the same cycle.
//   Next hit_req is accepted the cycle after hit_done.
//   Hit on a dead brick, in a gap, or off-field: hit_done=1, hit_kill=0, no state change.
//  Pixel path (any state): pixel_on registered = active_pixels & in-brick(x,y) & alive[row][col].
//   A kill on cycle N hides the brick from pixel_on computed on cycle N+1 onward.
//  Widths: all geometry compares are done in 11 bits to avoid wrap on x+BRICK_W.
//   x=639 resolves col 4, in gap, so it is a miss.
// CONFIGURATION
//  BRICK_ROW_COLOR_EN defined:
//   pixel_color = per-row palette: row0 24'hFF0000, row1 24'hFF8000, row2 24'hFFFF00, row3 24'h00FF00,
//   rows>=4 repeat mod 4.
//   score adds (ROWS-row) per kill instead of 1, saturating.
//  BRICK_ROW_COLOR_EN undefined: pixel_color = 24'hFFFFFF whenever pixel_on; score +1 per kill.
// TESTING
//  1 Reset, then start. After FILL: bricks_left=20, state PLAY. Raster scan (x=130,y=10)
//    -> pixel_on=1 one cycle later. (x=125,y=10) -> 0.
//  2 hit_req at (130,10) -> hit_done 2 cycles later, hit_kill=1, bricks_left=19, score=1.
//    Repeat same hit -> hit_kill=0, counts unchanged. Pixel (130,10) now 0.
//  3 Gaps/off-field: (126,10), (10,25), (10,2), (10,400) -> each gives hit_done with hit_kill=0.
//    hit_req while hit_busy is ignored: exactly one hit_done.
//  4 Kill all 20 bricks -> bricks_left=0, level_clear=1 next cycle. Then start -> level_clear=0,
//    score=0, bricks_left=20 after 4 FILL cycles.
//  5 Assert rst low mid-FILL and mid-hit -> all outputs at reset values, no hit_done.
//    start during a hit -> hit aborted.
//  6 With BRICK_ROW_COLOR_EN: pixel in row 2 -> pixel_color=24'hFFFF00. Kill in row 0 -> score +4.

Source files
------------

// File: rtl/brick_field_ctrl.sv
// brick_field_ctrl: live/dead state of the brick wall for the brick breaker game.
// Loads a fresh wall on start, resolves ball contacts to a brick through a
// two-stage hit pipeline, counts bricks and score, flags level clear, and
// drives a registered per-pixel brick mask for the VGA colour mux.
// Optional feature macro: BRICK_ROW_COLOR_EN (per-row palette and row-weighted score).
module brick_field_ctrl #(
    parameter int COLS    = 5,
    parameter int ROWS    = 4,
    parameter int BRICK_W = 124,
    parameter int BRICK_H = 20,
    parameter int PITCH_X = 128,
    parameter int PITCH_Y = 24,
    parameter int TOP_Y   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [9:0]                     x,
    input  logic [9:0]                     y,
    input  logic                           active_pixels,
    output logic                           pixel_on,
    output logic [23:0]                    pixel_color,
    input  logic                           hit_req,
    input  logic [9:0]                     hit_x,
    input  logic [9:0]                     hit_y,
    output logic                           hit_busy,
    output logic                           hit_done,
    output logic                           hit_kill,
    output logic [$clog2(COLS*ROWS+1)-1:0] bricks_left,
    output logic [15:0]                    score,
    output logic                           level_clear
);

    localparam int NB    = COLS * ROWS;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int BL_W  = $clog2(NB + 1);
    localparam int PX_SH = $clog2(PITCH_X);
    localparam logic [NB-1:0] ROW_MASK = NB'({COLS{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_PLAY, S_CLEAR} state_t;

    typedef struct packed {
        logic       found;
        logic [7:0] row;
        logic [7:0] col;
    } loc_t;

    state_t          state, state_nxt;
    logic [NB-1:0]   alive;
    logic [7:0]      fill_row;
    logic            accept;
    logic            vld_p0, vld_p1;
    logic [9:0]      hx_p0, hy_p0;
    loc_t            loc_p1;
    logic            kill_p1;
    loc_t            pix_loc;
    logic            pix_hit;

    // Geometry lookup in 11 bits; rows are resolved by a comparator chain.
    function automatic loc_t locate(input logic [9:0] px, input logic [9:0] py);
        loc_t        l;
        logic [10:0] xx, yy, col, xoff, yrel;
        xx   = {1'b0, px};
        yy   = {1'b0, py};
        col  = xx >> PX_SH;
        xoff = xx & 11'(PITCH_X - 1);
        yrel = yy - 11'(TOP_Y);
        l.found = 1'b0;
        l.row   = 8'd0;
        l.col   = 8'(col);
        if (yy >= 11'(TOP_Y) && col < 11'(COLS) && xoff < 11'(BRICK_W)) begin
            for (int r = 0; r < ROWS; r++) begin
                if (yrel >= 11'(r * PITCH_Y) && yrel < 11'(r * PITCH_Y + BRICK_H)) begin
                    l.found = 1'b1;
                    l.row   = 8'(r);
                end
            end
        end
        return l;
    endfunction

    function automatic logic [IDX_W-1:0] brick_idx(input loc_t l);
        return IDX_W'(32'(l.row) * COLS + 32'(l.col));
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[16] ? 16'hFFFF : t[15:0];
    endfunction

`ifdef BRICK_ROW_COLOR_EN
    function automatic logic [23:0] row_color(input logic [7:0] r);
        case (r[1:0])
            2'd0:    return 24'hFF0000;
            2'd1:    return 24'hFF8000;
            2'd2:    return 24'hFFFF00;
            default: return 24'h00FF00;
        endcase
    endfunction
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode plus busy / clear / hit-accept outputs.
    always_comb begin
        state_nxt   = state;
        hit_busy    = (state == S_FILL) | vld_p0 | vld_p1;
        level_clear = (state == S_CLEAR);
        accept      = 1'b0;
        if (start) begin
            state_nxt = S_FILL;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_FILL:  if (fill_row == 8'(ROWS - 1)) state_nxt = S_PLAY;
                S_PLAY: begin
                    accept = hit_req & ~hit_busy;
                    if (bricks_left == '0) state_nxt = S_CLEAR;
                end
                default: state_nxt = S_CLEAR;
            endcase
        end
    end

    // Stage 0 -> 1 -> 2 of the hit pipeline: control bits (start aborts in-flight hits).
    always_ff @(posedge clk) begin
        if (!rst || start) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            hit_done <= 1'b0;
            hit_kill <= 1'b0;
        end else begin
            vld_p0   <= accept;
            vld_p1   <= vld_p0;
            hit_done <= vld_p1;
            hit_kill <= kill_p1;
        end
    end

    // Hit datapath: latch contact point, then resolve it to a brick location.
    always_ff @(posedge clk) begin
        if (accept) begin
            hx_p0 <= hit_x;
            hy_p0 <= hit_y;
        end
        loc_p1 <= locate(hx_p0, hy_p0);
    end

    assign kill_p1 = vld_p1 & loc_p1.found & alive[brick_idx(loc_p1)];

    // Wall bitmap, fill sequencing, brick count and score.
    always_ff @(posedge clk) begin
        if (!rst || start) begin
            alive       <= '0;
            fill_row    <= 8'd0;
            bricks_left <= '0;
            score       <= 16'd0;
        end else if (state == S_FILL) begin
            alive    <= alive | (ROW_MASK << (32'(fill_row) * COLS));
            fill_row <= fill_row + 8'd1;
            if (fill_row == 8'(ROWS - 1)) bricks_left <= BL_W'(NB);
        end else if (kill_p1) begin
            alive[brick_idx(loc_p1)] <= 1'b0;
            bricks_left              <= bricks_left - BL_W'(1);
`ifdef BRICK_ROW_COLOR_EN
            score <= sat_add(score, 16'(ROWS) - 16'(loc_p1.row));
`else
            score <= sat_add(score, 16'd1);
`endif
        end
    end

    assign pix_loc = locate(x, y);
    assign pix_hit = active_pixels & pix_loc.found & alive[brick_idx(pix_loc)];

    // Registered pixel mask and colour for the VGA mux.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pixel_on    <= 1'b0;
            pixel_color <= 24'h0;
        end else begin
            pixel_on <= pix_hit;
`ifdef BRICK_ROW_COLOR_EN
            pixel_color <= pix_hit ? row_color(pix_loc.row) : 24'h0;
`else
            pixel_color <= pix_hit ? 24'hFFFFFF : 24'h0;
`endif
        end
    end

endmodule

// File: tb/tb_brick_field_ctrl.sv
// tb_brick_field_ctrl: directed and randomized checks of brick_field_ctrl
// against a behavioural wall/score model using plain division/modulo geometry.
module tb_brick_field_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  x, y;
    logic        active_pixels;
    logic        pixel_on;
    logic [23:0] pixel_color;
    logic        hit_req;
    logic [9:0]  hit_x, hit_y;
    logic        hit_busy, hit_done, hit_kill;
    logic [4:0]  bricks_left;
    logic [15:0] score;
    logic        level_clear;

    int checks = 0;
    int errors = 0;

    bit alive_m [4][5];
    int count_m, score_m;
    bit play_m, clear_m;

    brick_field_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .active_pixels(active_pixels), .pixel_on(pixel_on), .pixel_color(pixel_color),
        .hit_req(hit_req), .hit_x(hit_x), .hit_y(hit_y), .hit_busy(hit_busy),
        .hit_done(hit_done), .hit_kill(hit_kill), .bricks_left(bricks_left),
        .score(score), .level_clear(level_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference geometry from the plain rules.
    function automatic bit m_loc(input int px, input int py, output int r, output int c);
        c = px / 128;
        r = 0;
        if (px % 128 >= 124) return 1'b0;
        if (py < 4) return 1'b0;
        if ((py - 4) % 24 >= 20) return 1'b0;
        r = (py - 4) / 24;
        if (c >= 5 || r >= 4) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_clear;
        foreach (alive_m[r, c]) alive_m[r][c] = 1'b0;
        count_m = 0;
        score_m = 0;
        play_m  = 1'b0;
        clear_m = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pixel_on"},    32'(pixel_on), 32'd0);
        chk({tag, "_pixel_color"}, 32'(pixel_color), 32'd0);
        chk({tag, "_hit_busy"},    32'(hit_busy), 32'd0);
        chk({tag, "_hit_done"},    32'(hit_done), 32'd0);
        chk({tag, "_hit_kill"},    32'(hit_kill), 32'd0);
        chk({tag, "_bricks_left"}, 32'(bricks_left), 32'd0);
        chk({tag, "_score"},       32'(score), 32'd0);
        chk({tag, "_level_clear"}, 32'(level_clear), 32'd0);
    endtask

    // Start pulse and four FILL cycles; hit_req held during FILL must be ignored.
    task automatic do_fill;
        start = 1'b1;
        tick;
        start = 1'b0;
        m_clear();
        chk("fill_level_clear", 32'(level_clear), 32'd0);
        chk("fill_score", 32'(score), 32'd0);
        chk("fill_bricks0", 32'(bricks_left), 32'd0);
        chk("fill_busy", 32'(hit_busy), 32'd1);
        hit_x = 10'd130; hit_y = 10'd10; hit_req = 1'b1;
        tick; tick; tick;
        hit_req = 1'b0;
        chk("fill_bricks_mid", 32'(bricks_left), 32'd0);
        tick;
        foreach (alive_m[r, c]) alive_m[r][c] = 1'b1;
        count_m = 20;
        play_m  = 1'b1;
        chk("fill_bricks_full", 32'(bricks_left), 32'd20);
        chk("fill_busy_done", 32'(hit_busy), 32'd0);
    endtask

    task automatic pix(input int px, input int py, input bit act);
        int r, c;
        bit on;
        logic [23:0] col;
        x = 10'(px); y = 10'(py); active_pixels = act;
        tick;
        on = act && m_loc(px, py, r, c) && alive_m[r][c];
`ifdef BRICK_ROW_COLOR_EN
        case (r % 4)
            0:       col = 24'hFF0000;
            1:       col = 24'hFF8000;
            2:       col = 24'hFFFF00;
            default: col = 24'h00FF00;
        endcase
`else
        col = 24'hFFFFFF;
`endif
        if (!on) col = 24'h0;
        chk("pixel_on", 32'(pixel_on), 32'(on));
        chk("pixel_color", 32'(pixel_color), 32'(col));
    endtask

    task automatic do_hit(input int hx, input int hy);
        int r, c, inc;
        bit inb, kill, acc;
        acc = play_m;
        hit_x = 10'(hx); hit_y = 10'(hy); hit_req = 1'b1;
        tick;
        hit_req = 1'b0;
        chk("hit_busy_c0", 32'(hit_busy), 32'(acc));
        tick;
        chk("hit_done_c1", 32'(hit_done), 32'd0);
        tick;
        inb  = m_loc(hx, hy, r, c);
        kill = acc && inb && alive_m[r][c];
        chk("hit_done", 32'(hit_done), 32'(acc));
        chk("hit_kill", 32'(hit_kill), 32'(kill));
        chk("hit_busy_c2", 32'(hit_busy), 32'd0);
        if (kill) begin
`ifdef BRICK_ROW_COLOR_EN
            inc = 4 - r;
`else
            inc = 1;
`endif
            alive_m[r][c] = 1'b0;
            count_m--;
            score_m = (score_m + inc > 65535) ? 65535 : score_m + inc;
        end
        chk("bricks_left", 32'(bricks_left), 32'(count_m));
        chk("score", 32'(score), 32'(score_m));
        chk("level_clear_c2", 32'(level_clear), 32'(clear_m));
        tick;
        if (play_m && count_m == 0) begin
            play_m  = 1'b0;
            clear_m = 1'b1;
        end
        chk("hit_done_c3", 32'(hit_done), 32'd0);
        chk("level_clear", 32'(level_clear), 32'(clear_m));
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; hit_req = 1'b0; active_pixels = 1'b0;
        x = '0; y = '0; hit_x = '0; hit_y = '0;
        m_clear();
        tick; tick;
        chk_reset("rst");
        rst = 1'b1;
        tick;
        chk_reset("idle");

        // Fresh wall and raster lookups.
        do_fill();
        pix(130, 10, 1'b1);
        pix(125, 10, 1'b1);
        pix(130, 10, 1'b0);
        pix(639, 10, 1'b1);
        pix(300, 80, 1'b1);
        pix(10, 100, 1'b1);

        // Kill, repeat on dead brick, pixel disappears.
        do_hit(130, 10);
        do_hit(130, 10);
        pix(130, 10, 1'b1);

        // Gaps and off-field.
        do_hit(126, 10);
        do_hit(10, 25);
        do_hit(10, 2);
        do_hit(10, 400);
        do_hit(639, 10);

        // hit_req held while busy: only the first request is served.
        hit_x = 10'd258; hit_y = 10'd10; hit_req = 1'b1;
        tick;
        hit_x = 10'd386;
        n = 0;
        tick; n += int'(hit_done);
        tick; n += int'(hit_done);
        hit_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            n += int'(hit_done);
        end
        alive_m[0][2] = 1'b0;
        count_m--;
`ifdef BRICK_ROW_COLOR_EN
        score_m += 4;
`else
        score_m += 1;
`endif
        chk("busy_ignore_dones", 32'(n), 32'd1);
        chk("busy_ignore_bricks", 32'(bricks_left), 32'(count_m));
        chk("busy_ignore_score", 32'(score), 32'(score_m));

        // Randomized hits and pixels.
        for (int i = 0; i < 40; i++) begin
            int hx, hy;
            if ($urandom_range(1, 0) == 1) begin
                hx = $urandom_range(4, 0) * 128 + $urandom_range(127, 0);
                hy = 4 + $urandom_range(3, 0) * 24 + $urandom_range(23, 0);
            end else begin
                hx = $urandom_range(1023, 0);
                hy = $urandom_range(1023, 0);
            end
            do_hit(hx, hy);
            pix($urandom_range(700, 0), $urandom_range(120, 0), 1'b1);
        end

        // Clear the level.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                do_hit(c * 128 + 60, 4 + r * 24 + 10);
        chk("all_bricks_left", 32'(bricks_left), 32'd0);
        chk("all_level_clear", 32'(level_clear), 32'd1);
        do_hit(130, 10);

        // Restart from CLEARED.
        do_fill();
        pix(130, 10, 1'b1);
        do_hit(10, 90);

        // Reset during FILL.
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        rst = 1'b0; tick; rst = 1'b1;
        m_clear();
        chk_reset("rst_fill");
        pix(130, 10, 1'b1);
        do_hit(130, 10);

        // Reset during a hit.
        do_fill();
        hit_x = 10'd130; hit_y = 10'd10; hit_req = 1'b1;
        tick;
        hit_req = 1'b0;
        tick;
        rst = 1'b0; tick; rst = 1'b1;
        m_clear();
        chk_reset("rst_hit");
        tick;
        chk("rst_hit_no_done", 32'(hit_done), 32'd0);

        // start during a hit aborts it.
        do_fill();
        hit_x = 10'd130; hit_y = 10'd10; hit_req = 1'b1;
        tick;
        hit_req = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            n += int'(hit_done);
        end
        m_clear();
        foreach (alive_m[r, c]) alive_m[r][c] = 1'b1;
        count_m = 20;
        play_m  = 1'b1;
        chk("abort_no_done", 32'(n), 32'd0);
        chk("abort_bricks", 32'(bricks_left), 32'd20);
        chk("abort_score", 32'(score), 32'd0);
        pix(130, 10, 1'b1);
        do_hit(300, 58);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
